// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502 status register slice.
//  flag_op_t : flag update command decoded by the sequencer
//  P_*       : bit positions inside the processor status byte
//  P_RESET   : status value after reset ({N,V,1,1,D,I,Z,C} = 0011_0100)
//  pack_status() : assembles a status byte from individual flags
package cpu6502_pkg;

    typedef enum logic [3:0] {
        FOP_NONE   = 4'd0,
        FOP_NZ     = 4'd1,
        FOP_NZC    = 4'd2,
        FOP_NVZC   = 4'd3,
        FOP_BIT    = 4'd4,
        FOP_PULL   = 4'd5,
        FOP_CLC    = 4'd6,
        FOP_SEC    = 4'd7,
        FOP_CLI    = 4'd8,
        FOP_SEI    = 4'd9,
        FOP_CLD    = 4'd10,
        FOP_SED    = 4'd11,
        FOP_CLV    = 4'd12,
        FOP_INTENT = 4'd13,
        FOP_RSV14  = 4'd14,
        FOP_RSV15  = 4'd15
    } flag_op_t;

    localparam int unsigned P_C = 0;
    localparam int unsigned P_Z = 1;
    localparam int unsigned P_I = 2;
    localparam int unsigned P_D = 3;
    localparam int unsigned P_B = 4;
    localparam int unsigned P_U = 5;
    localparam int unsigned P_V = 6;
    localparam int unsigned P_N = 7;

    localparam logic [7:0] P_RESET = 8'h34;

    // Bit 5 is hard-wired to 1; bit 4 is supplied by the caller.
    function automatic logic [7:0] pack_status(
        input logic n,
        input logic v,
        input logic b,
        input logic d,
        input logic i,
        input logic z,
        input logic c
    );
        return {n, v, 1'b1, b, d, i, z, c};
    endfunction

endpackage

// File: rtl/cpu_int_sync.sv
// Interrupt pin front end: synchronizes irq/nmi and latches NMI rising edges.
//  clk, reset   : clock, asynchronous active-high reset
//  rdy          : advance enable; every flop holds when low
//  irq, nmi     : raw request pins (active-high)
//  nmi_ack      : NMI vector fetch taken, clears the latched edge
//  irq_s        : synchronized irq level
//  nmi_pending  : latched NMI edge awaiting service
module cpu_int_sync #(
    parameter int unsigned NMI_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rdy,
    input  logic irq,
    input  logic nmi,
    input  logic nmi_ack,
    output logic irq_s,
    output logic nmi_pending
);

    logic [NMI_SYNC_STAGES-1:0] irq_sr;
    logic [NMI_SYNC_STAGES-1:0] nmi_sr;
    logic                       nmi_s;
    logic                       nmi_prev;
    logic                       nmi_edge;

    assign irq_s    = irq_sr[NMI_SYNC_STAGES-1];
    assign nmi_s    = nmi_sr[NMI_SYNC_STAGES-1];
    assign nmi_edge = nmi_s & ~nmi_prev;

    // Synchronizer chains plus edge memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_sr   <= '0;
            nmi_sr   <= '0;
            nmi_prev <= 1'b0;
        end else if (rdy) begin
            irq_sr[0] <= irq;
            nmi_sr[0] <= nmi;
            for (int k = 1; k < int'(NMI_SYNC_STAGES); k++) begin
                irq_sr[k] <= irq_sr[k-1];
                nmi_sr[k] <= nmi_sr[k-1];
            end
            nmi_prev <= nmi_s;
        end
    end

    // A fresh edge beats a simultaneous ack; edges while pending merge into one NMI.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_pending <= 1'b0;
        end else if (rdy) begin
            if (nmi_edge) begin
                nmi_pending <= 1'b1;
            end else if (nmi_ack) begin
                nmi_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_status_reg.sv
// 6502 processor status register (P) with IRQ/NMI qualification.
//  clk, reset  : clock, asynchronous active-high reset
//  RDY         : global advance enable
//  flag_op     : flag update command applied at the next edge
//  alu_co/v/z/n: registered ALU flag outputs
//  DI          : data bus in (PLP/RTI pull, BIT operand)
//  b_flag      : B bit inserted into the push byte
//  sync        : opcode fetch strobe (instruction boundary)
//  irq, nmi    : interrupt request pins; nmi_ack clears pending NMI
//  P, P_push   : status byte and stack push byte
//  CI, BCD     : carry and decimal mode to the ALU
//  int_req     : interrupt to be taken at next sync
//  nmi_pending : latched NMI edge
// Build option: STATUS_BCD_EN drives BCD from D; without it BCD is tied low
// while D is still stored and visible (2A03-style).
module cpu_status_reg
    import cpu6502_pkg::*;
#(
    parameter int unsigned NMI_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RDY,
    input  flag_op_t   flag_op,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic [7:0] DI,
    input  logic       b_flag,
    input  logic       sync,
    input  logic       irq,
    input  logic       nmi,
    input  logic       nmi_ack,
    output logic [7:0] P,
    output logic [7:0] P_push,
    output logic       CI,
    output logic       BCD,
    output logic       int_req,
    output logic       nmi_pending
);

    logic c_q, z_q, i_q, d_q, v_q, n_q, i_eff_q;
    logic c_nx, z_nx, i_nx, d_nx, v_nx, n_nx, i_eff_nx;
    logic irq_s;
    logic unused_di;

    // PULL ignores bits 5 and 4 of the pulled byte.
    assign unused_di = ^DI[5:4];

    // Next-flag decode.
    always_comb begin
        c_nx     = c_q;
        z_nx     = z_q;
        i_nx     = i_q;
        d_nx     = d_q;
        v_nx     = v_q;
        n_nx     = n_q;
        // I_eff lags I by one instruction: it only follows I at an opcode fetch.
        i_eff_nx = sync ? i_q : i_eff_q;
        case (flag_op)
            FOP_NZ: begin
                n_nx = alu_n;
                z_nx = alu_z;
            end
            FOP_NZC: begin
                n_nx = alu_n;
                z_nx = alu_z;
                c_nx = alu_co;
            end
            FOP_NVZC: begin
                n_nx = alu_n;
                z_nx = alu_z;
                c_nx = alu_co;
                v_nx = alu_v;
            end
            FOP_BIT: begin
                n_nx = DI[P_N];
                v_nx = DI[P_V];
                z_nx = alu_z;
            end
            FOP_PULL: begin
                n_nx = DI[P_N];
                v_nx = DI[P_V];
                d_nx = DI[P_D];
                i_nx = DI[P_I];
                z_nx = DI[P_Z];
                c_nx = DI[P_C];
            end
            FOP_CLC: c_nx = 1'b0;
            FOP_SEC: c_nx = 1'b1;
            FOP_CLI: i_nx = 1'b0;
            FOP_SEI: i_nx = 1'b1;
            FOP_CLD: d_nx = 1'b0;
            FOP_SED: d_nx = 1'b1;
            FOP_CLV: v_nx = 1'b0;
            FOP_INTENT: begin
                // Mask IRQ immediately so the vector fetch cannot re-enter.
                i_nx     = 1'b1;
                i_eff_nx = 1'b1;
            end
            default: ;
        endcase
    end

    // Flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            i_q     <= 1'b1;
            d_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            i_eff_q <= 1'b1;
        end else if (RDY) begin
            c_q     <= c_nx;
            z_q     <= z_nx;
            i_q     <= i_nx;
            d_q     <= d_nx;
            v_q     <= v_nx;
            n_q     <= n_nx;
            i_eff_q <= i_eff_nx;
        end
    end

    cpu_int_sync #(
        .NMI_SYNC_STAGES(NMI_SYNC_STAGES)
    ) u_int_sync (
        .clk        (clk),
        .reset      (reset),
        .rdy        (RDY),
        .irq        (irq),
        .nmi        (nmi),
        .nmi_ack    (nmi_ack),
        .irq_s      (irq_s),
        .nmi_pending(nmi_pending)
    );

    assign P       = pack_status(n_q, v_q, 1'b1,   d_q, i_q, z_q, c_q);
    assign P_push  = pack_status(n_q, v_q, b_flag, d_q, i_q, z_q, c_q);
    assign CI      = c_q;
    // Built only from flops, so flag_op cannot reach int_req within a cycle.
    assign int_req = nmi_pending | (irq_s & ~i_eff_q);

`ifdef STATUS_BCD_EN
    assign BCD = d_q;
`else
    assign BCD = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_status_reg.sv
// Scoreboard bench for cpu_status_reg: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_cpu_status_reg;
    import cpu6502_pkg::*;

    localparam int unsigned STAGES = 2;
`ifdef STATUS_BCD_EN
    localparam logic BCD_ON = 1'b1;
`else
    localparam logic BCD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rdy;
    flag_op_t   flag_op;
    logic       alu_co, alu_v, alu_z, alu_n;
    logic [7:0] di;
    logic       b_flag;
    logic       sync;
    logic       irq, nmi, nmi_ack;
    logic [7:0] p, p_push;
    logic       ci, bcd, int_req, nmi_pending;

    cpu_status_reg #(.NMI_SYNC_STAGES(STAGES)) dut (
        .clk        (clk),
        .reset      (reset),
        .RDY        (rdy),
        .flag_op    (flag_op),
        .alu_co     (alu_co),
        .alu_v      (alu_v),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .DI         (di),
        .b_flag     (b_flag),
        .sync       (sync),
        .irq        (irq),
        .nmi        (nmi),
        .nmi_ack    (nmi_ack),
        .P          (p),
        .P_push     (p_push),
        .CI         (ci),
        .BCD        (bcd),
        .int_req    (int_req),
        .nmi_pending(nmi_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] push;
        logic       ci;
        logic       bcd;
        logic       intr;
        logic       pend;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Derive the dependent outputs from a hand-computed status byte.
    function automatic exp_t mk(input logic [7:0] pv, input logic bf, input logic intr, input logic pend);
        exp_t e;
        e.p    = pv;
        e.push = {pv[7:5], bf, pv[3:0]};
        e.ci   = pv[0];
        e.bcd  = BCD_ON & pv[3];
        e.intr = intr;
        e.pend = pend;
        return e;
    endfunction

    task automatic expect_state(input string nm, input logic [7:0] pv, input logic intr, input logic pend);
        exp_q.push_back(mk(pv, b_flag, intr, pend));
        name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    exp_t  mon_e;
    string mon_n;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if ({p, p_push, ci, bcd, int_req, nmi_pending} !== mon_e) begin
                errors++;
                $display("FAIL %s: got P=%h P_push=%h CI=%b BCD=%b int_req=%b nmi_pending=%b; want P=%h P_push=%h CI=%b BCD=%b int_req=%b nmi_pending=%b",
                         mon_n, p, p_push, ci, bcd, int_req, nmi_pending,
                         mon_e.p, mon_e.push, mon_e.ci, mon_e.bcd, mon_e.intr, mon_e.pend);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        rdy     = 1'b1;
        flag_op = FOP_NONE;
        alu_co  = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
        di      = 8'h00;
        b_flag  = 1'b0;
        sync    = 1'b0;
        irq     = 1'b0; nmi = 1'b0; nmi_ack = 1'b0;

        step(2);
        expect_state("reset_asserted", 8'h34, 1'b0, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            expect_state("reset_hold", 8'h34, 1'b0, 1'b0);
        end

        // ADC-style update: N=1 V=1 Z=0 C=1
        alu_co = 1'b1; alu_v = 1'b1; alu_z = 1'b0; alu_n = 1'b1;
        flag_op = FOP_NVZC;
        step(1); flag_op = FOP_NONE;
        expect_state("nvzc", 8'hF5, 1'b0, 1'b0);

        // RDY low freezes everything
        rdy = 1'b0; flag_op = FOP_PULL; di = 8'h00;
        step(1);
        expect_state("rdy_hold", 8'hF5, 1'b0, 1'b0);
        flag_op = FOP_NONE; rdy = 1'b1;

        di = 8'hCF; flag_op = FOP_PULL;
        step(1); flag_op = FOP_NONE;
        expect_state("pull_cf", 8'hFF, 1'b0, 1'b0);

        di = 8'h00; flag_op = FOP_PULL;
        step(1); flag_op = FOP_NONE; b_flag = 1'b1;
        expect_state("pull_00_bflag", 8'h30, 1'b0, 1'b0);
        step(1); b_flag = 1'b0;

        // BIT: N=DI7 V=DI6 Z=alu_z, C untouched
        di = 8'h40; alu_z = 1'b1; flag_op = FOP_BIT;
        step(1); flag_op = FOP_NONE;
        expect_state("bit", 8'h72, 1'b0, 1'b0);
        flag_op = FOP_CLV;
        step(1); flag_op = FOP_NONE;
        expect_state("clv", 8'h32, 1'b0, 1'b0);
        flag_op = FOP_SEC;
        step(1); flag_op = FOP_NONE;
        expect_state("sec", 8'h33, 1'b0, 1'b0);
        flag_op = FOP_SEI;
        step(1); flag_op = FOP_NONE;
        expect_state("sei", 8'h37, 1'b0, 1'b0);

        // IRQ latency through CLI
        sync = 1'b1; step(1); sync = 1'b0;
        irq = 1'b1;
        step(STAGES + 1);
        expect_state("irq_masked", 8'h37, 1'b0, 1'b0);
        flag_op = FOP_CLI;
        step(1); flag_op = FOP_NONE;
        expect_state("cli_before_sync", 8'h33, 1'b0, 1'b0);
        sync = 1'b1;
        step(1); sync = 1'b0;
        expect_state("cli_after_sync", 8'h33, 1'b1, 1'b0);
        flag_op = FOP_INTENT;
        step(1); flag_op = FOP_NONE;
        expect_state("intent", 8'h37, 1'b0, 1'b0);
        irq = 1'b0;

        // NMI edge latency and single capture
        nmi = 1'b1;
        for (int k = 1; k <= int'(STAGES) + 1; k++) begin
            step(1);
            expect_state("nmi_latency", 8'h37, (k == int'(STAGES) + 1), (k == int'(STAGES) + 1));
        end
        step(1);
        nmi = 1'b0;
        step(4);
        expect_state("nmi_once", 8'h37, 1'b1, 1'b1);

        // New edge coinciding with ack keeps pending set
        nmi = 1'b1;
        step(STAGES);
        nmi_ack = 1'b1;
        step(1); nmi_ack = 1'b0;
        expect_state("ack_vs_edge", 8'h37, 1'b1, 1'b1);
        nmi_ack = 1'b1;
        step(1); nmi_ack = 1'b0;
        expect_state("ack_clear", 8'h37, 1'b0, 1'b0);
        nmi = 1'b0;

        flag_op = FOP_SED;
        step(1); flag_op = FOP_NONE;
        expect_state("sed", 8'h3F, 1'b0, 1'b0);
        flag_op = FOP_CLD;
        step(1); flag_op = FOP_NONE;
        expect_state("cld", 8'h37, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle discards a pending NMI
        step(2);
        nmi = 1'b1;
        step(STAGES + 1);
        expect_state("pre_reset", 8'h37, 1'b1, 1'b1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        expect_state("reset_mid", 8'h34, 1'b0, 1'b0);
        nmi = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        step(STAGES + 2);
        expect_state("post_reset", 8'h34, 1'b0, 1'b0);

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
